// File: rtl/vpu_operand_fetch_sched_if.sv
// Handshake and SRAM bus bundle for the VPU operand-fetch scheduler.
// The slave modport is the scheduler; master is decode/consumer/SRAM side.
interface vpu_operand_fetch_sched_if #(
  parameter int SRC_CNT    = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int BANK_CNT   = 4,
  parameter int BANK_DEPTH = 1024,
  parameter int DATA_WIDTH = 512,
  parameter int CNT_WIDTH  = $clog2(SRC_CNT + 1)
);
  localparam int DLG = $clog2(BANK_DEPTH);

  logic                           req_valid;
  logic                           req_ready;
  logic [CNT_WIDTH-1:0]           req_src_cnt;
  logic [SRC_CNT*ADDR_WIDTH-1:0]  req_addr;
  logic [BANK_CNT-1:0]            bank_rd_en;
  logic [BANK_CNT*DLG-1:0]        bank_rd_addr;
  logic [BANK_CNT*DATA_WIDTH-1:0] bank_rd_data;
  logic                           op_valid;
  logic                           op_ready;
  logic [SRC_CNT*DATA_WIDTH-1:0]  op_data;
  logic [CNT_WIDTH-1:0]           op_cnt;
  logic                           op_err;

  modport master (
    output req_valid, req_src_cnt, req_addr, bank_rd_data, op_ready,
    input  req_ready, bank_rd_en, bank_rd_addr, op_valid, op_data, op_cnt, op_err
  );

  modport slave (
    input  req_valid, req_src_cnt, req_addr, bank_rd_data, op_ready,
    output req_ready, bank_rd_en, bank_rd_addr, op_valid, op_data, op_cnt, op_err
  );
endinterface

// File: rtl/vpu_operand_fetch_sched.sv
// Operand-fetch scheduler: maps source addresses to bank/row, serialises
// bank conflicts, merges identical bank/row reads, collects read data and
// presents one operand bundle per instruction.
module vpu_operand_fetch_sched #(
  parameter int SRC_CNT      = 3,
  parameter int ADDR_WIDTH   = 32,
  parameter int BANK_CNT     = 4,
  parameter int BANK_DEPTH   = 1024,
  parameter int DATA_WIDTH   = 512,
  parameter int RD_LAT       = 1,
  parameter int BANK_SEL_LSB = 1,
  parameter int CNT_WIDTH    = $clog2(SRC_CNT + 1)
) (
  input logic                      clk,
  input logic                      rst,
  vpu_operand_fetch_sched_if.slave bus
);
  localparam int OFF = $clog2(DATA_WIDTH);
  localparam int BLG = $clog2(BANK_CNT);
  localparam int DLG = $clog2(BANK_DEPTH);
  localparam int HI  = OFF + BLG + DLG;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t                                 state_q;
  logic                                   req_ready_q;
  logic [BANK_CNT-1:0]                    bank_rd_en_q;
  logic [BANK_CNT-1:0][DLG-1:0]           bank_rd_addr_q;
  logic                                   op_valid_q;
  logic [SRC_CNT-1:0][DATA_WIDTH-1:0]     op_data_q;
  logic [CNT_WIDTH-1:0]                   op_cnt_q;
  logic                                   op_err_q;
  logic [SRC_CNT-1:0][BLG-1:0]            bank_q;
  logic [SRC_CNT-1:0][DLG-1:0]            row_q;
  logic [SRC_CNT-1:0]                     pending_q;
  // Slot masks per bank, stage 0 aligned with the strobe; stage RD_LAT retires.
  logic [BANK_CNT-1:0][SRC_CNT-1:0]       tag_q [0:RD_LAT];

  logic [SRC_CNT-1:0][ADDR_WIDTH-1:0]     req_addr_s;
  logic                                   unused_offset_s;
  logic [CNT_WIDTH-1:0]                   cnt_clamp_s;
  logic                                   cnt_ovf_s;
  logic                                   range_err_s;
  logic [SRC_CNT-1:0][BLG-1:0]            src_bank_s;
  logic [SRC_CNT-1:0][DLG-1:0]            src_row_s;
  logic [SRC_CNT-1:0]                     src_pend_s;
  logic [BANK_CNT-1:0]                    grant_en_s;
  logic [BANK_CNT-1:0][DLG-1:0]           grant_row_s;
  logic [BANK_CNT-1:0][SRC_CNT-1:0]       grant_mask_s;
  logic [SRC_CNT-1:0]                     granted_s;
  logic [SRC_CNT-1:0]                     remain_s;
  logic                                   tags_busy_s;
  logic                                   accept_s;
  logic                                   issue_s;

  assign req_addr_s = bus.req_addr;
  assign accept_s   = (state_q == S_IDLE) && req_ready_q && bus.req_valid;
  assign issue_s    = accept_s || (state_q == S_ISSUE);

  // Clamp the source count and flag out-of-range addresses of the incoming request.
  always_comb begin
    unused_offset_s = 1'b0;
    range_err_s     = 1'b0;
    cnt_ovf_s       = (bus.req_src_cnt > CNT_WIDTH'(SRC_CNT));
    cnt_clamp_s     = cnt_ovf_s ? CNT_WIDTH'(SRC_CNT) : bus.req_src_cnt;
    for (int i = 0; i < SRC_CNT; i++) begin
      unused_offset_s = unused_offset_s ^ (^req_addr_s[i][OFF-1:0]);
      range_err_s = range_err_s | ((i < int'(cnt_clamp_s)) &&
                    ((req_addr_s[i] >> HI) != {ADDR_WIDTH{1'b0}}));
    end
  end

  // Select the slot source: live request while accepting, latched slots while issuing.
  always_comb begin
    for (int i = 0; i < SRC_CNT; i++) begin
      if (state_q == S_IDLE) begin
        src_pend_s[i] = (i < int'(cnt_clamp_s));
        if (BANK_SEL_LSB != 0) begin
          src_bank_s[i] = req_addr_s[i][OFF +: BLG];
          src_row_s[i]  = req_addr_s[i][OFF+BLG +: DLG];
        end else begin
          src_row_s[i]  = req_addr_s[i][OFF +: DLG];
          src_bank_s[i] = req_addr_s[i][OFF+DLG +: BLG];
        end
      end else begin
        src_pend_s[i] = pending_q[i];
        src_bank_s[i] = bank_q[i];
        src_row_s[i]  = row_q[i];
      end
    end
  end

  // Per bank: pick the lowest pending slot, then merge every pending slot on the same row.
  always_comb begin
    grant_en_s   = {BANK_CNT{1'b0}};
    grant_row_s  = {(BANK_CNT*DLG){1'b0}};
    grant_mask_s = {(BANK_CNT*SRC_CNT){1'b0}};
    granted_s    = {SRC_CNT{1'b0}};
    for (int b = 0; b < BANK_CNT; b++) begin
      for (int i = 0; i < SRC_CNT; i++) begin
        grant_row_s[b] = (src_pend_s[i] && (src_bank_s[i] == BLG'(b)) && !grant_en_s[b]) ?
                         src_row_s[i] : grant_row_s[b];
        grant_en_s[b]  = grant_en_s[b] | (src_pend_s[i] && (src_bank_s[i] == BLG'(b)));
      end
      for (int j = 0; j < SRC_CNT; j++) begin
        grant_mask_s[b][j] = grant_en_s[b] && src_pend_s[j] &&
                             (src_bank_s[j] == BLG'(b)) && (src_row_s[j] == grant_row_s[b]);
      end
      granted_s = granted_s | grant_mask_s[b];
    end
    remain_s = src_pend_s & ~granted_s;
  end

  // Any read still in flight ahead of the retiring stage keeps the FSM waiting.
  always_comb begin
    tags_busy_s = 1'b0;
    for (int s = 0; s < RD_LAT; s++) begin
      tags_busy_s = tags_busy_s | (tag_q[s] != {(BANK_CNT*SRC_CNT){1'b0}});
    end
  end

  // Control FSM, strobe/tag pipeline and operand collection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      req_ready_q    <= 1'b1;
      bank_rd_en_q   <= {BANK_CNT{1'b0}};
      bank_rd_addr_q <= {(BANK_CNT*DLG){1'b0}};
      op_valid_q     <= 1'b0;
      op_data_q      <= {(SRC_CNT*DATA_WIDTH){1'b0}};
      op_cnt_q       <= {CNT_WIDTH{1'b0}};
      op_err_q       <= 1'b0;
      bank_q         <= {(SRC_CNT*BLG){1'b0}};
      row_q          <= {(SRC_CNT*DLG){1'b0}};
      pending_q      <= {SRC_CNT{1'b0}};
      for (int s = 0; s <= RD_LAT; s++) tag_q[s] <= {(BANK_CNT*SRC_CNT){1'b0}};
    end else begin
      tag_q[0]     <= issue_s ? grant_mask_s : {(BANK_CNT*SRC_CNT){1'b0}};
      for (int s = 1; s <= RD_LAT; s++) tag_q[s] <= tag_q[s-1];
      bank_rd_en_q <= issue_s ? grant_en_s : {BANK_CNT{1'b0}};
      for (int b = 0; b < BANK_CNT; b++) begin
        if (issue_s && grant_en_s[b]) bank_rd_addr_q[b] <= grant_row_s[b];
        for (int i = 0; i < SRC_CNT; i++) begin
          if (tag_q[RD_LAT][b][i]) op_data_q[i] <= bus.bank_rd_data[b*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            bank_q      <= src_bank_s;
            row_q       <= src_row_s;
            pending_q   <= remain_s;
            op_cnt_q    <= cnt_clamp_s;
            op_err_q    <= cnt_ovf_s | range_err_s;
            op_data_q   <= {(SRC_CNT*DATA_WIDTH){1'b0}};
            req_ready_q <= 1'b0;
            if (cnt_clamp_s == {CNT_WIDTH{1'b0}}) begin
              state_q    <= S_OUT;
              op_valid_q <= 1'b1;
            end else if (remain_s == {SRC_CNT{1'b0}}) begin
              state_q <= S_WAIT;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          pending_q <= remain_s;
          if (remain_s == {SRC_CNT{1'b0}}) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!tags_busy_s) begin
            state_q    <= S_OUT;
            op_valid_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (bus.op_ready) begin
            state_q     <= S_IDLE;
            op_valid_q  <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q & ~rst;
  assign bus.bank_rd_en   = bank_rd_en_q;
  assign bus.bank_rd_addr = bank_rd_addr_q;
  assign bus.op_valid     = op_valid_q;
  assign bus.op_data      = op_data_q;
  assign bus.op_cnt       = op_cnt_q;
  assign bus.op_err       = op_err_q;
endmodule

// File: tb/tb_vpu_operand_fetch_sched.sv
// Testbench for vpu_operand_fetch_sched: directed scenarios plus random
// instructions checked against an address-arithmetic reference model.
module tb_vpu_operand_fetch_sched;
  localparam int SRC = 3, AW = 32, BC = 4, BD = 1024, DW = 512, CW = 3, DLG = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [BC-1:0] fe;

  always #5 clk = ~clk;

  vpu_operand_fetch_sched_if #(.SRC_CNT(SRC), .ADDR_WIDTH(AW), .BANK_CNT(BC), .BANK_DEPTH(BD),
                               .DATA_WIDTH(DW), .CNT_WIDTH(CW)) ifa ();
  vpu_operand_fetch_sched_if #(.SRC_CNT(SRC), .ADDR_WIDTH(AW), .BANK_CNT(BC), .BANK_DEPTH(BD),
                               .DATA_WIDTH(DW)) ifb ();

  vpu_operand_fetch_sched #(.SRC_CNT(SRC), .ADDR_WIDTH(AW), .BANK_CNT(BC), .BANK_DEPTH(BD),
                            .DATA_WIDTH(DW), .RD_LAT(1), .BANK_SEL_LSB(1), .CNT_WIDTH(CW))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  vpu_operand_fetch_sched #(.SRC_CNT(SRC), .ADDR_WIDTH(AW), .BANK_CNT(BC), .BANK_DEPTH(BD),
                            .DATA_WIDTH(DW), .RD_LAT(1), .BANK_SEL_LSB(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  // Content of bank b, row r.
  function automatic logic [DW-1:0] memval(input int b, input int r);
    logic [DW-1:0] v;
    for (int w = 0; w < DW/32; w++) v[w*32 +: 32] = {8'(b) ^ 8'hC3, 8'(w), 16'(r)} ^ 32'h5A5A_0000;
    return v;
  endfunction

  // SRAM with 1-cycle read latency; garbage on the bus when not reading.
  always @(posedge clk) begin
    for (int b = 0; b < BC; b++) begin
      if (ifa.bank_rd_en[b]) ifa.bank_rd_data[b*DW +: DW] <= memval(b, int'(ifa.bank_rd_addr[b*DLG +: DLG]));
      else                   ifa.bank_rd_data[b*DW +: DW] <= {16{$urandom()}};
      if (ifb.bank_rd_en[b]) ifb.bank_rd_data[b*DW +: DW] <= memval(b, int'(ifb.bank_rd_addr[b*DLG +: DLG]));
      else                   ifb.bank_rd_data[b*DW +: DW] <= {16{$urandom()}};
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] v;
    v = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 3)) << 9) | 32'($urandom_range(0, 511));
    if ($urandom_range(0, 7) == 0) v = v | (32'h1 << $urandom_range(21, 31));
    return v;
  endfunction

  // One instruction on DUT A, predicted from the address arithmetic alone.
  task automatic run_a(input int cnt, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input int hold, output logic [BC-1:0] first_en);
    logic [AW-1:0] a [SRC];
    logic [DW-1:0] expd [SRC];
    int bk [SRC];
    int rw [SRC];
    int rows_in_bank [BC];
    int eff, k, pairs, lat, n, scyc, sbits;
    logic err, dup, ok, seen;
    logic [SRC*DW-1:0] snap;
    a[0] = a0; a[1] = a1; a[2] = a2;
    eff = (cnt > SRC) ? SRC : cnt;
    err = (cnt > SRC);
    pairs = 0;
    for (int b = 0; b < BC; b++) rows_in_bank[b] = 0;
    for (int i = 0; i < SRC; i++) begin
      bk[i] = int'((a[i] / 32'd512) % 32'd4);
      rw[i] = int'((a[i] / 32'd2048) % 32'd1024);
      expd[i] = (i < eff) ? memval(bk[i], rw[i]) : {DW{1'b0}};
      if (i < eff) begin
        if (a[i] >= 32'h0020_0000) err = 1'b1;
        dup = 1'b0;
        for (int j = 0; j < i; j++) if (bk[j] == bk[i] && rw[j] == rw[i]) dup = 1'b1;
        if (!dup) begin
          pairs++;
          rows_in_bank[bk[i]]++;
        end
      end
    end
    k = 0;
    for (int b = 0; b < BC; b++) if (rows_in_bank[b] > k) k = rows_in_bank[b];
    lat = (eff == 0) ? 1 : k + 2;

    n = 0;
    while (!ifa.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", ifa.req_ready, 1);
    ifa.req_valid = 1'b1;
    ifa.req_src_cnt = CW'(cnt);
    ifa.req_addr = {a[2], a[1], a[0]};
    ifa.op_ready = (hold == 0);
    @(posedge clk);
    first_en = {BC{1'b0}};
    scyc = 0; sbits = 0; n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      ifa.req_valid = 1'b0;
      if (n == 1) first_en = ifa.bank_rd_en;
      if (ifa.bank_rd_en != {BC{1'b0}}) begin
        scyc++;
        sbits += $countones(ifa.bank_rd_en);
        for (int b = 0; b < BC; b++) begin
          if (ifa.bank_rd_en[b]) begin
            ok = 1'b0;
            for (int i = 0; i < eff; i++)
              if (bk[i] == b && rw[i] == int'(ifa.bank_rd_addr[b*DLG +: DLG])) ok = 1'b1;
            chk($sformatf("strobe_row_b%0d", b), ok, 1);
          end
        end
      end
      seen = ifa.op_valid;
    end
    chk("op_valid_latency", n, lat);
    chk("strobe_cycles", scyc, k);
    chk("strobe_count", sbits, pairs);
    chk("op_cnt", ifa.op_cnt, eff);
    chk("op_err", ifa.op_err, err);
    for (int i = 0; i < SRC; i++) chk($sformatf("slot%0d", i), ifa.op_data[i*DW +: DW], expd[i]);
    snap = ifa.op_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", ifa.op_valid, 1);
      chk("hold_data", ifa.op_data == snap, 1);
      chk("hold_err", ifa.op_err, err);
      chk("hold_req_ready", ifa.req_ready, 0);
      chk("hold_strobe", ifa.bank_rd_en, 0);
    end
    ifa.op_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", ifa.op_valid, 0);
    chk("post_req_ready", ifa.req_ready, 1);
  endtask

  initial begin
    ifa.req_valid = 1'b0; ifa.req_src_cnt = 3'd0; ifa.req_addr = {(SRC*AW){1'b0}}; ifa.op_ready = 1'b1;
    ifb.req_valid = 1'b0; ifb.req_src_cnt = 2'd0; ifb.req_addr = {(SRC*AW){1'b0}}; ifb.op_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", ifa.req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready_after", ifa.req_ready, 1);
    chk("rst_strobe", ifa.bank_rd_en, 0);
    chk("rst_rd_addr", ifa.bank_rd_addr, 0);
    chk("rst_op_valid", ifa.op_valid, 0);
    chk("rst_op_data", ifa.op_data == {(SRC*DW){1'b0}}, 1);
    chk("rst_op_cnt", ifa.op_cnt, 0);
    chk("rst_op_err", ifa.op_err, 0);

    // Distinct banks, conflict, merge, backpressure.
    run_a(3, 32'h000, 32'h200, 32'h400, 0, fe);
    chk("t1_first_en", fe, 4'b0111);
    run_a(3, 32'h000, 32'h800, 32'h1000, 0, fe);
    chk("t2_first_en", fe, 4'b0001);
    run_a(3, 32'h200, 32'h200, 32'h400, 0, fe);
    chk("t3_first_en", fe, 4'b0110);
    run_a(3, 32'h600, 32'h000, 32'h1200, 4, fe);

    // Edge inputs.
    run_a(0, 32'h200, 32'h400, 32'h600, 0, fe);
    chk("cnt0_no_strobe", fe, 4'b0000);
    run_a(1, 32'h0020_0000, 32'h0, 32'h0, 0, fe);
    chk("range_first_en", fe, 4'b0001);
    run_a(5, 32'h000, 32'h200, 32'h400, 0, fe);

    // Row-major bank select on the second instance.
    @(negedge clk);
    ifb.req_valid = 1'b1; ifb.req_src_cnt = 2'd1; ifb.req_addr = {64'h0, 32'h0008_0200};
    @(posedge clk);
    @(negedge clk);
    ifb.req_valid = 1'b0;
    chk("b_strobe", ifb.bank_rd_en, 4'b0010);
    chk("b_row", ifb.bank_rd_addr[DLG +: DLG], 1);
    @(negedge clk);
    chk("b_valid_early", ifb.op_valid, 0);
    @(negedge clk);
    chk("b_valid", ifb.op_valid, 1);
    chk("b_slot0", ifb.op_data[0 +: DW], memval(1, 1));
    chk("b_err", ifb.op_err, 0);
    @(negedge clk);

    // Reset in the middle of a conflicting instruction.
    ifa.req_valid = 1'b1; ifa.req_src_cnt = 3'd3; ifa.req_addr = {32'h1000, 32'h800, 32'h000};
    @(posedge clk);
    @(negedge clk);
    ifa.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_strobe", ifa.bank_rd_en, 0);
    chk("abort_valid", ifa.op_valid, 0);
    chk("abort_req_ready", ifa.req_ready, 1);
    run_a(3, 32'h000, 32'h200, 32'h400, 0, fe);
    chk("abort_next_first_en", fe, 4'b0111);

    // Random instructions.
    for (int r = 0; r < 24; r++) begin
      run_a($urandom_range(0, 5), rnd_addr(), rnd_addr(), rnd_addr(), $urandom_range(0, 2), fe);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
